ioctl_upload_server: RTL and testbench
======================================

Name: ioctl_upload_server

Overview:
- Serves HPS ioctl upload (core-to-HPS) requests by reading bytes out of a core-side byte RAM, for example high-score or NVRAM contents.
- It is the read-back counterpart of the ROM download path; it sits between hps_io and a spare read port of the game RAM.
- It handles the request/wait handshake, arbitration against CPU access, and pausing the game CPU for the length of the transfer.

Parameters:
- AW, 10, RAM address width; upload image size is 2**AW bytes.
- INDEX, 8'd2, ioctl_index value this block answers to.
- RD_LAT, 2, cycles from mem_rd issue to valid mem_q (1..4).
- FILL, 8'hFF, byte returned for addresses at or beyond the image size.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ioctl_upload  in  1  HPS upload session active.
- ioctl_index  in  8  selected file index.
- ioctl_rd  in  1  one-cycle read strobe for ioctl_addr.
- ioctl_addr  in  25  byte address requested.
- ioctl_din  out  8  byte returned to HPS.
- ioctl_wait  out  1  stall HPS until ioctl_din is valid.
- mem_addr  out  AW  RAM read address.
- mem_rd  out  1  one-cycle RAM read strobe.
- mem_q  in  8  RAM read data, valid RD_LAT cycles after mem_rd.
- mem_busy  in  1  CPU owns the RAM port this cycle; do not issue.
- pause_cpu  out  1  freeze request to the game core.
- active  out  1  high while a matching upload session is in progress.

Behaviour:
- Reset values: ioctl_din=0, ioctl_wait=0, mem_rd=0, mem_addr=0, pause_cpu=0, active=0, state=IDLE.
- Match: sel = ioctl_upload & (ioctl_index==INDEX). active=sel, registered with 1-cycle delay. pause_cpu follows active.
- IDLE: on ioctl_rd & sel: latch addr, assert ioctl_wait in the next cycle.
  - addr >= 2**AW: go to PRESENT with ioctl_din=FILL; no RAM access.
  - Otherwise go to ARB.
- ARB: while mem_busy=1, stay. When mem_busy=0: mem_rd=1 for one cycle, mem_addr=addr[AW-1:0], load lat counter=RD_LAT, go to WAIT.
- WAIT: decrement the counter. When it reaches 0, capture mem_q into ioctl_din and go to PRESENT.
- PRESENT: drop ioctl_wait; ioctl_din holds until the next capture. Return to IDLE.
- Latency: with mem_busy=0 and in-range addr, ioctl_wait is high for exactly RD_LAT+2 cycles after the ioctl_rd cycle.
- ioctl_rd arriving while not IDLE is ignored. The HPS protocol forbids this while ioctl_wait=1.
- ioctl_rd with sel=0 is ignored; ioctl_wait stays 0.
- ioctl_upload falls mid-transaction: abort to IDLE next cycle, ioctl_wait=0, mem_rd=0, ioctl_din unchanged, pause_cpu drops with active.
- Reset mid-operation: all outputs return to reset values immediately.
- mem_q is sampled only at the computed cycle; mem_busy is ignored once mem_rd has been issued.

Optional Feature:
- Macro: UPLOAD_CHECKSUM_EN.
- Defined:
  - The block keeps an 8-bit running sum of every in-range byte delivered in the session; the sum clears on the rising edge of active.
  - A read of addr==2**AW returns the two's complement of the sum, so the whole image plus the checksum byte sums to 0.
  - Addresses above 2**AW return FILL.
- Not defined: addr==2**AW returns FILL, and no sum register exists.

Test Plan:
- Single read: RD_LAT=2, RAM[0x005]=0xA7, sel=1, pulse ioctl_rd at addr 5 with mem_busy=0 -> mem_rd one cycle with mem_addr=5; ioctl_wait high 4 cycles; ioctl_din=0xA7 when wait falls.
- Arbitration: hold mem_busy=1 for 6 cycles after ioctl_rd -> no mem_rd during busy; mem_rd on the first free cycle; wait extended by 6 cycles; data correct.
- Out of range: AW=10, read addr 0x500 -> no mem_rd; ioctl_wait high 1 cycle; ioctl_din=0xFF.
- Index mismatch: ioctl_index=0, ioctl_rd pulses -> ioctl_wait=0, mem_rd=0, active=0, pause_cpu=0.
- Abort: drop ioctl_upload during WAIT -> next cycle ioctl_wait=0, state IDLE, pause_cpu=0; a new session's first read works normally.
- Checksum (UPLOAD_CHECKSUM_EN): AW=2, RAM={01,02,03,04}, read addrs 0..4 -> byte at addr 4 = 0xF6; re-open session and read addr 4 only -> 0x00.

Source files
------------

// File: rtl/ioctl_upload_server.sv
// ioctl_upload_server: answers HPS ioctl upload (core-to-HPS) reads by fetching
// bytes from a spare read port of a core-side byte RAM. It holds ioctl_wait
// while it arbitrates against the CPU and waits out the RAM read latency, and
// it asks the core to pause for as long as a matching upload session is open.
// Optional feature macro: UPLOAD_CHECKSUM_EN. When defined, a read of
// address 2**AW returns the two's complement of the 8-bit sum of all in-range
// bytes delivered in the current session.
module ioctl_upload_server #(
    parameter int          AW     = 10,
    parameter logic [7:0]  INDEX  = 8'd2,
    parameter int          RD_LAT = 2,
    parameter logic [7:0]  FILL   = 8'hFF
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_q,
    input  logic          mem_busy,
    output logic          pause_cpu,
    output logic          active
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_WAIT,
        S_PRESENT
    } state_t;

    // First address past the image; everything from here up is not RAM.
    localparam logic [24:0] IMG_SIZE = 25'd1 << AW;
    localparam logic [2:0]  LAT_INIT = 3'(RD_LAT);

    state_t        state_q, state_n;
    logic [AW-1:0] addr_q, addr_n;
    logic [2:0]    cnt_q, cnt_n;
    logic [7:0]    din_n;
    logic          wait_n;
    logic          rd_n;
    logic [AW-1:0] maddr_n;
    logic          sel;

`ifdef UPLOAD_CHECKSUM_EN
    logic [7:0]    sum_q, sum_n;
`endif

    assign sel = ioctl_upload && (ioctl_index == INDEX);

    // Next-state and next-output logic for the read transaction sequencer.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_n = state_q;
        addr_n  = addr_q;
        cnt_n   = cnt_q;
        din_n   = ioctl_din;
        wait_n  = ioctl_wait;
        rd_n    = 1'b0;
        maddr_n = mem_addr;
`ifdef UPLOAD_CHECKSUM_EN
        sum_n   = sum_q;
        // Session is opening this cycle (active rises on the next edge).
        if (sel && !active) begin
            sum_n = 8'd0;
        end
`endif

        if (!sel) begin
            // Session closed or index changed: abandon whatever was in flight.
            // Any RAM data already on its way is simply never sampled.
            state_n = S_IDLE;
            wait_n  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ioctl_rd) begin
                        wait_n = 1'b1;
                        addr_n = ioctl_addr[AW-1:0];
                        if (ioctl_addr >= IMG_SIZE) begin
                            // Beyond the image: answer immediately, no RAM access.
                            din_n   = FILL;
`ifdef UPLOAD_CHECKSUM_EN
                            if (ioctl_addr == IMG_SIZE) begin
                                din_n = 8'd0 - sum_n;
                            end
`endif
                            state_n = S_PRESENT;
                        end else begin
                            state_n = S_ARB;
                        end
                    end
                end
                S_ARB: begin
                    // The CPU has priority on the shared port; issue only when free.
                    if (!mem_busy) begin
                        rd_n    = 1'b1;
                        maddr_n = addr_q;
                        cnt_n   = LAT_INIT;
                        state_n = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Counter hits zero exactly in the cycle mem_q is valid.
                    if (cnt_q == 3'd0) begin
                        din_n   = mem_q;
                        wait_n  = 1'b0;
                        state_n = S_PRESENT;
`ifdef UPLOAD_CHECKSUM_EN
                        sum_n   = sum_n + mem_q;
`endif
                    end else begin
                        cnt_n = cnt_q - 3'd1;
                    end
                end
                S_PRESENT: begin
                    wait_n  = 1'b0;
                    state_n = S_IDLE;
                end
                default: begin
                    wait_n  = 1'b0;
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs; session flags follow sel one cycle late.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cnt_q      <= 3'd0;
            ioctl_din  <= 8'd0;
            ioctl_wait <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            active     <= 1'b0;
            pause_cpu  <= 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
            sum_q      <= 8'd0;
`endif
        end else begin
            // NOTE: non-blocking assignments here so every register updates
            // from the same pre-edge values, independent of statement order.
            state_q    <= state_n;
            addr_q     <= addr_n;
            cnt_q      <= cnt_n;
            ioctl_din  <= din_n;
            ioctl_wait <= wait_n;
            mem_rd     <= rd_n;
            mem_addr   <= maddr_n;
            active     <= sel;
            pause_cpu  <= sel;
`ifdef UPLOAD_CHECKSUM_EN
            sum_q      <= sum_n;
`endif
        end
    end

endmodule

// File: tb/tb_ioctl_upload_server.sv
// Testbench for ioctl_upload_server: table-driven reads, hand-written corner
// sequences (index mismatch, abort, reset mid-read) and randomized reads
// checked against a behavioural model of the upload protocol.
module tb_ioctl_upload_server;

    localparam int         AW     = 10;
    localparam int         RD_LAT = 2;
    localparam logic [7:0] INDEX  = 8'd2;
    localparam logic [7:0] FILL   = 8'hFF;
    localparam int         IMG    = 1 << AW;

    logic          clk_sys;
    logic          reset;
    logic          ioctl_upload;
    logic [7:0]    ioctl_index;
    logic          ioctl_rd;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_din;
    logic          ioctl_wait;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [7:0]    mem_q;
    logic          mem_busy;
    logic          pause_cpu;
    logic          active;

    ioctl_upload_server #(
        .AW(AW), .INDEX(INDEX), .RD_LAT(RD_LAT), .FILL(FILL)
    ) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
        .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_q(mem_q),
        .mem_busy(mem_busy), .pause_cpu(pause_cpu), .active(active)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // RAM model: data appears RD_LAT cycles after the mem_rd cycle, and only
    // then; otherwise mem_q carries a junk pattern.
    logic [7:0] ram [IMG];
    logic [7:0] pd  [RD_LAT];
    logic       pv  [RD_LAT];

    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= 8'd0;
            end
        end else begin
            pv[0] <= mem_rd;
            pd[0] <= ram[mem_addr];
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end
    assign mem_q = pv[RD_LAT-1] ? pd[RD_LAT-1] : 8'hE1;

    int checks = 0;
    int errors = 0;
    int model_sum = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Behavioural expectation of the byte returned for an address.
    function automatic logic [7:0] exp_byte(input logic [24:0] a);
        if (a < 25'(IMG)) return ram[a[AW-1:0]];
`ifdef UPLOAD_CHECKSUM_EN
        if (a == 25'(IMG)) return 8'(-model_sum);
`endif
        return FILL;
    endfunction

    // One HPS read: pulse ioctl_rd, hold mem_busy for 'busy' cycles, then
    // watch until ioctl_wait falls (bounded).
    task automatic do_read(input logic [24:0] addr, input int busy,
                           output logic [7:0] din, output int wait_cnt,
                           output int rd_cnt, output int rd_cycle,
                           output logic [AW-1:0] rd_addr, output bit timed_out);
        wait_cnt = 0; rd_cnt = 0; rd_cycle = -1; rd_addr = '0; din = 8'd0; timed_out = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_rd = 1'b1; ioctl_addr = addr; mem_busy = 1'b0;
        @(posedge clk_sys); #1;
        ioctl_rd = 1'b0; ioctl_addr = 25'($urandom);
        for (int k = 1; k <= 64; k++) begin
            if (k <= busy)          mem_busy = 1'b1;
            else if (k == busy + 1) mem_busy = 1'b0;
            else                    mem_busy = 1'($urandom_range(0, 1));
            @(negedge clk_sys);
            if (mem_rd) begin
                rd_cnt++;
                rd_cycle = k;
                rd_addr  = mem_addr;
            end
            if (ioctl_wait) wait_cnt++;
            else begin
                din = ioctl_din;
                timed_out = 1'b0;
                break;
            end
            @(posedge clk_sys); #1;
        end
        mem_busy = 1'b0;
    endtask

    // Read checked against the behavioural model.
    task automatic compare_read(input string tag, input logic [24:0] addr, input int busy);
        logic [7:0]    din, exp_din;
        logic [AW-1:0] rd_addr;
        int            wait_cnt, rd_cnt, rd_cycle;
        bit            timed_out, in_range;
        in_range = (addr < 25'(IMG));
        exp_din  = exp_byte(addr);
        do_read(addr, busy, din, wait_cnt, rd_cnt, rd_cycle, rd_addr, timed_out);
        check($sformatf("%s timeout", tag), 32'(timed_out), 32'd0);
        check($sformatf("%s din", tag), 32'(din), 32'(exp_din));
        check($sformatf("%s wait_len", tag), 32'(wait_cnt), in_range ? 32'(RD_LAT + 2 + busy) : 32'd1);
        check($sformatf("%s rd_count", tag), 32'(rd_cnt), in_range ? 32'd1 : 32'd0);
        if (in_range) begin
            check($sformatf("%s rd_cycle", tag), 32'(rd_cycle), 32'(busy + 2));
            check($sformatf("%s rd_addr", tag), 32'(rd_addr), 32'(addr[AW-1:0]));
            model_sum = model_sum + int'(ram[addr[AW-1:0]]);
        end
    endtask

    typedef struct {
        logic [24:0] addr;
        int          busy;
        logic [7:0]  din;
        int          wt;
        int          rd;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]    din, prev_din;
        logic [AW-1:0] rd_addr;
        int            wait_cnt, rd_cnt, rd_cycle;
        bit            timed_out, bad;
        logic [24:0]   a;

        vecs[0] = '{addr: 25'h005,     busy: 0, din: 8'hA7, wt: 4,  rd: 1};
        vecs[1] = '{addr: 25'h005,     busy: 6, din: 8'hA7, wt: 10, rd: 1};
        vecs[2] = '{addr: 25'h500,     busy: 0, din: FILL,  wt: 1,  rd: 0};
        vecs[3] = '{addr: 25'h3FF,     busy: 3, din: 8'h3C, wt: 7,  rd: 1};
        vecs[4] = '{addr: 25'h000,     busy: 1, din: 8'h11, wt: 5,  rd: 1};
        vecs[5] = '{addr: 25'h1FFFFFF, busy: 0, din: FILL,  wt: 1,  rd: 0};

        for (int i = 0; i < IMG; i++) ram[i] = 8'($urandom);
        ram[5] = 8'hA7; ram[10'h3FF] = 8'h3C; ram[0] = 8'h11;

        reset = 1'b1; ioctl_upload = 1'b0; ioctl_index = INDEX;
        ioctl_rd = 1'b0; ioctl_addr = '0; mem_busy = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_sys);
        check("rst din", 32'(ioctl_din), 32'd0);
        check("rst wait", 32'(ioctl_wait), 32'd0);
        check("rst mem_rd", 32'(mem_rd), 32'd0);
        check("rst mem_addr", 32'(mem_addr), 32'd0);
        check("rst pause", 32'(pause_cpu), 32'd0);
        check("rst active", 32'(active), 32'd0);

        // Session open: active and pause follow one cycle later
        @(posedge clk_sys); #1; reset = 1'b0;
        @(posedge clk_sys); #1; ioctl_upload = 1'b1; model_sum = 0;
        @(negedge clk_sys);
        check("open active_early", 32'(active), 32'd0);
        @(negedge clk_sys);
        check("open active", 32'(active), 32'd1);
        check("open pause", 32'(pause_cpu), 32'd1);

        // Table-driven reads
        for (int i = 0; i < 6; i++) begin
            do_read(vecs[i].addr, vecs[i].busy, din, wait_cnt, rd_cnt, rd_cycle, rd_addr, timed_out);
            check($sformatf("vec%0d timeout", i), 32'(timed_out), 32'd0);
            check($sformatf("vec%0d din", i), 32'(din), 32'(vecs[i].din));
            check($sformatf("vec%0d wait_len", i), 32'(wait_cnt), 32'(vecs[i].wt));
            check($sformatf("vec%0d rd_count", i), 32'(rd_cnt), 32'(vecs[i].rd));
            if (vecs[i].rd == 1) begin
                check($sformatf("vec%0d rd_addr", i), 32'(rd_addr), 32'(vecs[i].addr[AW-1:0]));
                model_sum = model_sum + int'(vecs[i].din);
            end
        end

        // Index mismatch: reads ignored, session flags drop
        @(posedge clk_sys); #1; ioctl_index = 8'd0;
        @(posedge clk_sys); #1; ioctl_rd = 1'b1; ioctl_addr = 25'h005;
        bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_sys);
            bad = bad | ioctl_wait | mem_rd | active | pause_cpu;
            @(posedge clk_sys); #1; ioctl_rd = 1'b0;
        end
        check("mismatch quiet", 32'(bad), 32'd0);

        // Abort during WAIT
        ioctl_index = INDEX; model_sum = 0;
        compare_read("pre_abort", 25'h3FF, 0);
        prev_din = 8'h3C;
        @(posedge clk_sys); #1; ioctl_rd = 1'b1; ioctl_addr = 25'h005;
        @(posedge clk_sys); #1; ioctl_rd = 1'b0;
        @(posedge clk_sys); #1;
        @(posedge clk_sys); #1; ioctl_upload = 1'b0;
        @(negedge clk_sys);
        check("abort pre_wait", 32'(ioctl_wait), 32'd1);
        @(posedge clk_sys); #1;
        @(negedge clk_sys);
        check("abort wait", 32'(ioctl_wait), 32'd0);
        check("abort mem_rd", 32'(mem_rd), 32'd0);
        check("abort pause", 32'(pause_cpu), 32'd0);
        check("abort active", 32'(active), 32'd0);
        check("abort din", 32'(ioctl_din), 32'(prev_din));
        @(negedge clk_sys);
        check("abort din_hold", 32'(ioctl_din), 32'(prev_din));
        @(posedge clk_sys); #1; ioctl_upload = 1'b1; model_sum = 0;
        compare_read("after_abort", 25'h005, 0);

        // Randomized reads against the model
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0:       a = 25'(IMG);
                1:       a = 25'(IMG + 1 + int'($urandom_range(0, 5000)));
                default: a = 25'($urandom_range(0, IMG - 1));
            endcase
            compare_read($sformatf("rnd%0d", n), a, int'($urandom_range(0, 4)));
        end

        // Reopen the session: running sum restarts
        @(posedge clk_sys); #1; ioctl_upload = 1'b0;
        @(posedge clk_sys); #1; ioctl_upload = 1'b1; model_sum = 0;
        compare_read("reopen_img", 25'(IMG), 0);
        compare_read("reopen_a", 25'h001, 0);
        compare_read("reopen_b", 25'h002, 2);
        compare_read("reopen_img2", 25'(IMG), 0);

        // Reset in the middle of a read
        compare_read("pre_rst", 25'h005, 0);
        @(posedge clk_sys); #1; ioctl_rd = 1'b1; ioctl_addr = 25'h006;
        @(posedge clk_sys); #1; ioctl_rd = 1'b0; mem_busy = 1'b1;
        @(negedge clk_sys);
        check("midrst pre_wait", 32'(ioctl_wait), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst wait", 32'(ioctl_wait), 32'd0);
        check("midrst din", 32'(ioctl_din), 32'd0);
        check("midrst active", 32'(active), 32'd0);
        check("midrst pause", 32'(pause_cpu), 32'd0);
        check("midrst mem_rd", 32'(mem_rd), 32'd0);
        check("midrst mem_addr", 32'(mem_addr), 32'd0);
        @(posedge clk_sys); #1; reset = 1'b0; mem_busy = 1'b0; model_sum = 0;
        compare_read("post_rst", 25'h005, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
